// File: rtl/controlador_sincronia_vga.sv
// controlador_sincronia_vga: VGA raster sequencer.
// Owns the pixel prescaler and the column/row counters. It decodes the
// active-video window, the sync pulses and the line/frame strobes.
// All decoded outputs are registered from the next counter values, so
// they change on the same edge as columna/fila.
// Build option: define SYNC_POLARIDAD_POSITIVA_EN for active-high hsync/vsync
// (default build: active-low).
module controlador_sincronia_vga #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int DIV_PIXEL = 2
) (
    input  logic       reloj,
    input  logic       reset,
    input  logic       habilitar,
    output logic [9:0] columna,
    output logic [9:0] fila,
    output logic       video_activo,
    output logic       hsync,
    output logic       vsync,
    output logic       tick_pixel,
    output logic       inicio_linea,
    output logic       inicio_cuadro
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_INI  = H_VISIBLE + H_FRONT;
    localparam int HS_FIN  = HS_INI + H_SYNC;
    localparam int VS_INI  = V_VISIBLE + V_FRONT;
    localparam int VS_FIN  = VS_INI + V_SYNC;
    localparam int DIV_W   = (DIV_PIXEL > 1) ? $clog2(DIV_PIXEL) : 1;

`ifdef SYNC_POLARIDAD_POSITIVA_EN
    localparam logic SYNC_ACTIVO = 1'b1;
`else
    localparam logic SYNC_ACTIVO = 1'b0;
`endif
    localparam logic SYNC_INACTIVO = ~SYNC_ACTIVO;

    // Counters are 10 bits wide, so totals above 1024 cannot be represented.
    if (H_TOTAL > 1024 || V_TOTAL > 1024 || DIV_PIXEL < 1) begin : g_param_invalidos
        $error("controlador_sincronia_vga: H_TOTAL/V_TOTAL must be <= 1024 and DIV_PIXEL >= 1");
    end

    logic [DIV_W-1:0] div;
    logic             avance;
    logic [9:0]       columna_sig;
    logic [9:0]       fila_sig;
    logic             video_sig;
    logic             hsync_sig;
    logic             vsync_sig;
    logic [10:0]      col_ext;
    logic [10:0]      fila_ext;

    // Next counter position and the phase decode of that position.
    always_comb begin
        avance      = habilitar && (div == DIV_W'(DIV_PIXEL - 1));
        columna_sig = columna;
        fila_sig    = fila;
        if (avance) begin
            if (columna == 10'(H_TOTAL - 1)) begin
                columna_sig = '0;
                fila_sig    = (fila == 10'(V_TOTAL - 1)) ? '0 : fila + 10'd1;
            end else begin
                columna_sig = columna + 10'd1;
            end
        end
        // One extra bit so a boundary equal to 1024 still compares correctly.
        col_ext   = {1'b0, columna_sig};
        fila_ext  = {1'b0, fila_sig};
        video_sig = (col_ext < 11'(H_VISIBLE)) && (fila_ext < 11'(V_VISIBLE));
        hsync_sig = ((col_ext >= 11'(HS_INI)) && (col_ext < 11'(HS_FIN))) ? SYNC_ACTIVO : SYNC_INACTIVO;
        vsync_sig = ((fila_ext >= 11'(VS_INI)) && (fila_ext < 11'(VS_FIN))) ? SYNC_ACTIVO : SYNC_INACTIVO;
    end

    // Prescaler, counters and registered decode/strobes.
    always_ff @(posedge reloj or negedge reset) begin
        if (!reset) begin
            div           <= '0;
            columna       <= 10'(H_TOTAL - 1);
            fila          <= 10'(V_TOTAL - 1);
            video_activo  <= 1'b0;
            hsync         <= SYNC_INACTIVO;
            vsync         <= SYNC_INACTIVO;
            tick_pixel    <= 1'b0;
            inicio_linea  <= 1'b0;
            inicio_cuadro <= 1'b0;
        end else begin
            if (habilitar) begin
                div <= avance ? '0 : div + DIV_W'(1);
            end
            columna       <= columna_sig;
            fila          <= fila_sig;
            video_activo  <= video_sig;
            hsync         <= hsync_sig;
            vsync         <= vsync_sig;
            tick_pixel    <= avance;
            inicio_linea  <= avance && (columna_sig == '0);
            inicio_cuadro <= avance && (columna_sig == '0) && (fila_sig == '0);
        end
    end

endmodule

// File: tb/tb_controlador_sincronia_vga.sv
// Directed bench for controlador_sincronia_vga: a default-timing instance
// for reset, first-line decode and enable freeze; reduced-timing instances
// (DIV_PIXEL 2 and 1) for frame wrap, strobe spacing and mid-frame reset.
module tb_controlador_sincronia_vga;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_d, hab_d, rst_s, hab_s;
    logic [9:0] d_col, d_fila, s_col, s_fila, o_col, o_fila;
    logic       d_va, d_hs, d_vs, d_tick, d_linea, d_cuadro;
    logic       s_va, s_hs, s_vs, s_tick, s_linea, s_cuadro;
    logic       o_va, o_hs, o_vs, o_tick, o_linea, o_cuadro;

    int checks = 0;
    int errors = 0;

    controlador_sincronia_vga dut (
        .reloj(clk), .reset(rst_d), .habilitar(hab_d),
        .columna(d_col), .fila(d_fila), .video_activo(d_va),
        .hsync(d_hs), .vsync(d_vs), .tick_pixel(d_tick),
        .inicio_linea(d_linea), .inicio_cuadro(d_cuadro)
    );

    controlador_sincronia_vga #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .DIV_PIXEL(2)
    ) dut_s (
        .reloj(clk), .reset(rst_s), .habilitar(hab_s),
        .columna(s_col), .fila(s_fila), .video_activo(s_va),
        .hsync(s_hs), .vsync(s_vs), .tick_pixel(s_tick),
        .inicio_linea(s_linea), .inicio_cuadro(s_cuadro)
    );

    controlador_sincronia_vga #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .DIV_PIXEL(1)
    ) dut_o (
        .reloj(clk), .reset(rst_s), .habilitar(hab_s),
        .columna(o_col), .fila(o_fila), .video_activo(o_va),
        .hsync(o_hs), .vsync(o_vs), .tick_pixel(o_tick),
        .inicio_linea(o_linea), .inicio_cuadro(o_cuadro)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    int first_va_off, col_va_off, first_hs, first_hs_col, last_hs_col;
    int hs_low, va_cnt, tick_cnt, linea_cnt, cuadro_cnt, vs_low, o_tick_cnt;
    int frozen_bad, snap_col, snap_fila;

    initial begin
        rst_d = 1'b0; hab_d = 1'b0; rst_s = 1'b0; hab_s = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state, default timing
        check("rst_col", d_col, 799);
        check("rst_fila", d_fila, 524);
        check("rst_hsync", d_hs, 1);
        check("rst_vsync", d_vs, 1);
        check("rst_va", d_va, 0);
        check("rst_strobes", {d_tick, d_linea, d_cuadro}, 0);

        // Release: first advance on the second enabled edge
        hab_d = 1'b1; rst_d = 1'b1;
        @(negedge clk);
        check("e1_col", d_col, 799);
        check("e1_tick", d_tick, 0);
        @(negedge clk);
        check("e2_col", d_col, 0);
        check("e2_fila", d_fila, 0);
        check("e2_strobes", {d_tick, d_linea, d_cuadro}, 3'b111);
        check("e2_va", d_va, 1);
        check("e2_hsync", d_hs, 1);

        // One full line, edges 3..1602
        first_va_off = -1; col_va_off = -1; first_hs = -1;
        first_hs_col = -1; last_hs_col = -1;
        hs_low = 0; va_cnt = 0; tick_cnt = 0; linea_cnt = 0;
        for (int e = 3; e <= 1602; e++) begin
            @(negedge clk);
            if (!d_va && first_va_off < 0) begin
                first_va_off = e; col_va_off = int'(d_col);
            end
            if (!d_hs) begin
                hs_low++;
                if (first_hs < 0) begin
                    first_hs = e; first_hs_col = int'(d_col);
                end
                last_hs_col = int'(d_col);
            end
            if (d_va) va_cnt++;
            if (d_tick) tick_cnt++;
            if (d_linea) linea_cnt++;
        end
        check("va_off_edge", first_va_off, 1282);
        check("va_off_col", col_va_off, 640);
        check("hs_first_edge", first_hs, 1314);
        check("hs_first_col", first_hs_col, 656);
        check("hs_last_col", last_hs_col, 751);
        check("hs_low_cycles", hs_low, 192);
        check("va_cycles", va_cnt, 1280);
        check("tick_cycles", tick_cnt, 800);
        check("linea_spacing", linea_cnt, 1);
        check("line1_pos", {d_fila, d_col}, {10'd1, 10'd0});
        check("line1_strobes", {d_linea, d_cuadro}, 2'b10);

        // Freeze with div=1 for 37 cycles
        @(negedge clk);
        check("pre_freeze_tick", d_tick, 0);
        hab_d = 1'b0;
        frozen_bad = 0;
        repeat (37) begin
            @(negedge clk);
            if (d_col != 10'd0 || d_fila != 10'd1 || d_tick || d_linea || d_cuadro) frozen_bad++;
        end
        check("freeze_hold", frozen_bad, 0);
        hab_d = 1'b1;
        @(negedge clk);
        check("resume_col", d_col, 1);
        check("resume_tick", d_tick, 1);

        // Asynchronous reset between edges clears the strobe in flight
        #2 rst_d = 1'b0;
        #1;
        check("arst_col", d_col, 799);
        check("arst_fila", d_fila, 524);
        check("arst_tick", d_tick, 0);
        check("arst_hsync", d_hs, 1);

        // Reduced-timing instances: H_TOTAL=15, V_TOTAL=8
        @(negedge clk);
        check("s_rst_pos", {s_fila, s_col}, {10'd7, 10'd14});
        check("s_rst_sync", {s_hs, s_vs}, 2'b11);
        check("o_rst_col", o_col, 14);
        rst_s = 1'b1; hab_s = 1'b1;
        @(negedge clk);
        check("s_e1_col", s_col, 14);
        check("o_e1_pos", {o_fila, o_col}, 20'd0);
        check("o_e1_strobes", {o_tick, o_linea, o_cuadro}, 3'b111);
        @(negedge clk);
        check("s_e2_pos", {s_fila, s_col}, 20'd0);
        check("s_e2_strobes", {s_tick, s_linea, s_cuadro}, 3'b111);

        // One full frame, edges 3..242
        hs_low = 0; vs_low = 0; va_cnt = 0; tick_cnt = 0;
        linea_cnt = 0; cuadro_cnt = 0; o_tick_cnt = 0;
        snap_col = -1; snap_fila = -1;
        for (int e = 3; e <= 242; e++) begin
            @(negedge clk);
            if (e == 241) begin
                snap_col = int'(s_col); snap_fila = int'(s_fila);
            end
            if (!s_hs) hs_low++;
            if (!s_vs) vs_low++;
            if (s_va) va_cnt++;
            if (s_tick) tick_cnt++;
            if (s_linea) linea_cnt++;
            if (s_cuadro) cuadro_cnt++;
            if (o_tick) o_tick_cnt++;
        end
        check("s_wrap_from", {snap_fila[9:0], snap_col[9:0]}, {10'd7, 10'd14});
        check("s_wrap_to", {s_fila, s_col}, 20'd0);
        check("s_wrap_cuadro", s_cuadro, 1);
        check("s_cuadro_spacing", cuadro_cnt, 1);
        check("s_linea_count", linea_cnt, 8);
        check("s_vs_low", vs_low, 60);
        check("s_hs_low", hs_low, 48);
        check("s_va_cycles", va_cnt, 64);
        check("s_tick_cycles", tick_cnt, 120);
        check("o_tick_const", o_tick_cnt, 240);

        // Mid-frame asynchronous reset, then resumption
        repeat (100) @(negedge clk);
        check("s_mid_pos", {s_fila, s_col}, {10'd3, 10'd5});
        check("s_mid_va", s_va, 1);
        #2 rst_s = 1'b0;
        #1;
        check("s_arst_pos", {s_fila, s_col}, {10'd7, 10'd14});
        check("s_arst_va", s_va, 0);
        check("s_arst_hsync", s_hs, 1);
        @(negedge clk);
        rst_s = 1'b1;
        @(negedge clk);
        check("s_re1_col", s_col, 14);
        check("s_re1_tick", s_tick, 0);
        @(negedge clk);
        check("s_re2_pos", {s_fila, s_col}, 20'd0);
        check("s_re2_strobes", {s_tick, s_linea, s_cuadro, s_va}, 4'b1111);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
